// File: rtl/rs232_loader_if.sv
// Memory write port between the boot loader and the target memory.
// The loader holds mem_req/mem_addr/mem_wdata stable until mem_ready is seen.
interface rs232_loader_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;

   modport master (
      output mem_req,
      output mem_addr,
      output mem_wdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready
   );
endinterface

// File: rtl/rs232_loader.sv
// Serial boot loader: parses 'L' (load) and 'J' (jump) frames from the UART byte stream.
// Optional trailing checksum byte per frame is enabled by defining RS232_LOADER_CHECKSUM_EN.
module rs232_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
   parameter logic [7:0]  CMD_LOAD       = 8'h4C,
   parameter logic [7:0]  CMD_JUMP       = 8'h4A
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           rx_data_valid,
   input  logic [7:0]     rx_data,
   rs232_loader_if.master mem,
   output logic           boot_valid,
   output logic [31:0]    boot_addr,
   output logic           busy,
   output logic           error
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_JADDR
`ifdef RS232_LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

`ifdef RS232_LOADER_CHECKSUM_EN
   localparam state_t S_DONE = S_CSUM;
`else
   localparam state_t S_DONE = S_IDLE;
`endif

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_byteCnt;
   logic [23:0]      r_asm;
   logic [31:0]      r_addr;
   logic [15:0]      r_len;
   logic [CNT_W-1:0] r_idleCnt;
   logic             r_memReq;
   logic [31:0]      r_memAddr;
   logic [31:0]      r_memWdata;
   logic             r_bootValid;
   logic [31:0]      r_bootAddr;
   logic             r_error;
`ifdef RS232_LOADER_CHECKSUM_EN
   logic [7:0]       r_sum;
   logic             r_isJump;
   logic [7:0]       w_sumNext;
`endif

   logic [31:0] w_word;
   logic [15:0] w_len;
   logic        w_timeout;
   logic        w_byteInFrame;
   logic        w_addrDone;
   logic        w_lenDone;
   logic        w_wordDone;
   logic        w_jumpDone;

   // Fields arrive LSB first, so the newest byte always lands at the top of the word.
   assign w_word        = {rx_data, r_asm};
   assign w_len         = {rx_data, r_asm[23:16]};
   assign w_byteInFrame = rx_data_valid && (r_state != S_IDLE);
   assign w_timeout     = (r_state != S_IDLE) && !rx_data_valid && (r_idleCnt == CNT_LAST);
   assign w_addrDone    = rx_data_valid && (r_state == S_ADDR)  && (r_byteCnt == 2'd3);
   assign w_lenDone     = rx_data_valid && (r_state == S_LEN)   && (r_byteCnt == 2'd1);
   assign w_wordDone    = rx_data_valid && (r_state == S_DATA)  && (r_byteCnt == 2'd3);
   assign w_jumpDone    = rx_data_valid && (r_state == S_JADDR) && (r_byteCnt == 2'd3);
`ifdef RS232_LOADER_CHECKSUM_EN
   assign w_sumNext     = r_sum + rx_data;
`endif

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (rx_data_valid) begin
         case (r_state)
            S_IDLE: begin
               if (rx_data == CMD_LOAD)      w_next = S_ADDR;
               else if (rx_data == CMD_JUMP) w_next = S_JADDR;
            end
            S_ADDR:  if (r_byteCnt == 2'd3) w_next = S_LEN;
            S_LEN:   if (r_byteCnt == 2'd1) w_next = (w_len == 16'd0) ? S_DONE : S_DATA;
            S_DATA:  if (r_byteCnt == 2'd3 && r_len == 16'd1) w_next = S_DONE;
            S_JADDR: if (r_byteCnt == 2'd3) w_next = S_DONE;
            default: w_next = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_next = S_IDLE;
      end
   end

   // A word completing while the previous write is still unaccepted is dropped (overrun).
   always_ff @(posedge clock) begin
      if (reset) begin
         r_byteCnt   <= '0;
         r_asm       <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_idleCnt   <= '0;
         r_memReq    <= 1'b0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
         r_bootValid <= 1'b0;
         r_bootAddr  <= '0;
         r_error     <= 1'b0;
`ifdef RS232_LOADER_CHECKSUM_EN
         r_sum       <= '0;
         r_isJump    <= 1'b0;
`endif
      end else begin
         r_bootValid <= 1'b0;

         if (r_state == S_IDLE || rx_data_valid || w_timeout) r_idleCnt <= '0;
         else                                                 r_idleCnt <= r_idleCnt + CNT_W'(1);

         if (w_timeout) r_error <= 1'b1;

         if (r_memReq && mem.mem_ready) r_memReq <= 1'b0;

         if (w_byteInFrame) r_asm <= w_word[31:8];

         if (w_next != r_state)  r_byteCnt <= '0;
         else if (w_byteInFrame) r_byteCnt <= r_byteCnt + 2'd1;

         if (w_addrDone) r_addr <= w_word;
         if (w_lenDone)  r_len  <= w_len;

         if (w_wordDone) begin
            if (r_memReq && !mem.mem_ready) begin
               r_error <= 1'b1;
            end else begin
               r_memReq   <= 1'b1;
               r_memAddr  <= {r_addr[31:2], 2'b00};
               r_memWdata <= w_word;
            end
            r_addr <= r_addr + 32'd4;
            r_len  <= r_len - 16'd1;
         end

         if (w_jumpDone) begin
            r_bootAddr <= {w_word[31:2], 2'b00};
`ifndef RS232_LOADER_CHECKSUM_EN
            r_bootValid <= 1'b1;
`endif
         end

`ifdef RS232_LOADER_CHECKSUM_EN
         if (rx_data_valid && r_state == S_IDLE) begin
            r_sum    <= '0;
            r_isJump <= (rx_data == CMD_JUMP);
         end else if (rx_data_valid) begin
            r_sum <= w_sumNext;
         end

         if (rx_data_valid && r_state == S_CSUM) begin
            if (w_sumNext != 8'h00) r_error     <= 1'b1;
            else if (r_isJump)      r_bootValid <= 1'b1;
         end
`endif
      end
   end

   assign mem.mem_req   = r_memReq;
   assign mem.mem_addr  = r_memAddr;
   assign mem.mem_wdata = r_memWdata;
   assign boot_valid    = r_bootValid;
   assign boot_addr     = r_bootAddr;
   assign busy          = (r_state != S_IDLE) || r_memReq;
   assign error         = r_error;

endmodule

// File: tb/tb_rs232_loader.sv
// Self-checking bench for rs232_loader: a frame-level model predicts every write and boot,
// and one compare process checks them against the DUT on every cycle.
module tb_rs232_loader;

   localparam int unsigned TO       = 100;
   localparam logic [7:0]  CMD_LOAD = 8'h4C;
   localparam logic [7:0]  CMD_JUMP = 8'h4A;

   typedef logic [7:0] bytes_t [$];

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_data_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        boot_valid;
   logic [31:0] boot_addr;
   logic        busy;
   logic        error;

   rs232_loader_if memIf();

   rs232_loader #(
      .TIMEOUT_CYCLES(TO),
      .CMD_LOAD(CMD_LOAD),
      .CMD_JUMP(CMD_JUMP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .rx_data_valid(rx_data_valid),
      .rx_data(rx_data),
      .mem(memIf),
      .boot_valid(boot_valid),
      .boot_addr(boot_addr),
      .busy(busy),
      .error(error)
   );

   always #5 clock = ~clock;

   logic [31:0] expWrAddr[$];
   logic [31:0] expWrData[$];
   logic [31:0] expBoot[$];
   logic        expErr = 1'b0;
   int          nChecks = 0;
   int          nFail = 0;
   bit          readyLow = 1'b1;
   int          waitCnt = 0;
   bit          held = 1'b0;
   logic [31:0] heldAddr = '0;
   logic [31:0] heldData = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Random target back-pressure, bounded so a write is always accepted within a few cycles.
   always @(posedge clock) begin
      #1;
      if (memIf.mem_req) waitCnt++;
      else               waitCnt = 0;
      if (readyLow) memIf.mem_ready = 1'b0;
      else          memIf.mem_ready = (waitCnt >= 3) || ($urandom_range(0, 1) == 1);
   end

   // Every accepted write and every boot pulse must match the next model expectation.
   always @(negedge clock) begin
      if (reset) begin
         held = 1'b0;
      end else begin
         if (boot_valid) begin
            if (expBoot.size() == 0) checkOutput("spuriousBoot", 32'(boot_valid), 32'd0);
            else                     checkOutput("bootAddr", boot_addr, expBoot.pop_front());
         end
         if (memIf.mem_req) begin
            if (held) begin
               checkOutput("holdAddr", memIf.mem_addr, heldAddr);
               checkOutput("holdData", memIf.mem_wdata, heldData);
            end
            if (memIf.mem_ready) begin
               held = 1'b0;
               if (expWrAddr.size() == 0) begin
                  checkOutput("spuriousWrite", 32'(memIf.mem_req), 32'd0);
               end else begin
                  checkOutput("wrAddr", memIf.mem_addr, expWrAddr.pop_front());
                  checkOutput("wrData", memIf.mem_wdata, expWrData.pop_front());
               end
            end else begin
               held     = 1'b1;
               heldAddr = memIf.mem_addr;
               heldData = memIf.mem_wdata;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      @(posedge clock);
      #1;
      rx_data_valid = 1'b1;
      rx_data       = b;
      @(posedge clock);
      #1;
      rx_data_valid = 1'b0;
      rx_data       = 8'($urandom);
      repeat (gap) @(posedge clock);
   endtask

   task automatic sendFrame(input bytes_t q, input int gapMin, input int gapMax);
`ifdef RS232_LOADER_CHECKSUM_EN
      logic [7:0] s = 8'h00;
      for (int i = 1; i < q.size(); i++) s += q[i];
      q.push_back(8'h00 - s);
`endif
      foreach (q[i]) applyStimulus(q[i], $urandom_range(gapMin, gapMax));
   endtask

   task automatic doLoad(input logic [31:0] addr, input int n, input int gapMax);
      bytes_t      q;
      logic [31:0] w;
      q.push_back(CMD_LOAD);
      for (int k = 0; k < 4; k++) q.push_back(8'(addr >> (8 * k)));
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         expWrAddr.push_back((addr + 32'(4 * i)) & 32'hFFFF_FFFC);
         expWrData.push_back(w);
         for (int k = 0; k < 4; k++) q.push_back(8'(w >> (8 * k)));
      end
      sendFrame(q, 0, gapMax);
   endtask

   task automatic doJump(input logic [31:0] target, input int gapMax);
      bytes_t q;
      q.push_back(CMD_JUMP);
      for (int k = 0; k < 4; k++) q.push_back(8'(target >> (8 * k)));
      expBoot.push_back(target & 32'hFFFF_FFFC);
      sendFrame(q, 0, gapMax);
   endtask

   task automatic sendNoise(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         if (b == CMD_LOAD || b == CMD_JUMP) b = 8'h0D;
         applyStimulus(b, $urandom_range(0, 3));
      end
   endtask

   task automatic settle();
      repeat (20) @(posedge clock);
      @(negedge clock);
      checkOutput("busyIdle", 32'(busy), 32'd0);
      checkOutput("error", 32'(error), 32'(expErr));
   endtask

   task automatic doReset();
      @(posedge clock);
      #1;
      reset         = 1'b1;
      rx_data_valid = 1'b0;
      expWrAddr.delete();
      expWrData.delete();
      expBoot.delete();
      expErr = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rstReq", 32'(memIf.mem_req), 32'd0);
      checkOutput("rstAddr", memIf.mem_addr, 32'd0);
      checkOutput("rstWdata", memIf.mem_wdata, 32'd0);
      checkOutput("rstBootValid", 32'(boot_valid), 32'd0);
      checkOutput("rstBootAddr", boot_addr, 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstError", 32'(error), 32'd0);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      readyLow = 1'b0;
   endtask

   initial begin
      bytes_t q;

      doReset();

      // Load with leading CR/LF noise; literal expectations pin the byte order.
      applyStimulus(8'h0D, 1);
      applyStimulus(8'h0A, 1);
      q = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      expWrAddr.push_back(32'h0000_1000); expWrData.push_back(32'h4433_2211);
      expWrAddr.push_back(32'h0000_1004); expWrData.push_back(32'h8877_6655);
      sendFrame(q, 0, 2);
      settle();

      q = '{8'h4A, 8'h03, 8'h20, 8'h00, 8'h80};
      expBoot.push_back(32'h8000_2000);
      sendFrame(q, 0, 2);
      settle();

      doLoad(32'hFFFF_FFFC, 2, 1);
      settle();
      doLoad(32'h0000_4000, 0, 1);
      settle();

      // Back-pressure: first word held, second word overruns and is dropped.
      readyLow = 1'b1;
      q = '{8'h4C, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      expWrAddr.push_back(32'h0000_2000); expWrData.push_back(32'h4433_2211);
      expErr = 1'b1;
      sendFrame(q, 0, 0);
      repeat (5) @(posedge clock);
      @(negedge clock);
      checkOutput("bpHeldReq", 32'(memIf.mem_req), 32'd1);
      checkOutput("bpHeldAddr", memIf.mem_addr, 32'h0000_2000);
      readyLow = 1'b0;
      settle();

      // Timeout after exactly TO idle cycles inside a frame.
      doReset();
      applyStimulus(8'h4C, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h10, 0);
      repeat (TO - 1) @(posedge clock);
      @(negedge clock);
      checkOutput("toBeforeBusy", 32'(busy), 32'd1);
      checkOutput("toBeforeErr", 32'(error), 32'd0);
      @(posedge clock);
      @(negedge clock);
      checkOutput("toAfterBusy", 32'(busy), 32'd0);
      checkOutput("toAfterErr", 32'(error), 32'd1);
      expErr = 1'b1;
      doJump(32'h1234_5678, 2);
      settle();

      // Bytes arriving on the exact expiry cycle keep the frame alive.
      doReset();
      q = '{8'h4A, 8'h44, 8'h33, 8'h22, 8'h11};
      expBoot.push_back(32'h1122_3344);
      sendFrame(q, TO - 2, TO - 2);
      settle();

      // Reset while a write is pending abandons it.
      readyLow = 1'b1;
      q = '{8'h4C, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      sendFrame(q, 0, 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("midReq", 32'(memIf.mem_req), 32'd1);
      doReset();

      for (int f = 0; f < 25; f++) begin
         logic [31:0] a;
         sendNoise($urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) doJump(a, 4);
         else                           doLoad(a, $urandom_range(0, 3), 4);
         settle();
      end

`ifdef RS232_LOADER_CHECKSUM_EN
      q = '{8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      expBoot.push_back(32'h0000_0000);
      foreach (q[i]) applyStimulus(q[i], 1);
      settle();
      q = '{8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      expErr = 1'b1;
      foreach (q[i]) applyStimulus(q[i], 1);
      settle();
`endif

      checkOutput("writesLeft", 32'(expWrAddr.size()), 32'd0);
      checkOutput("bootsLeft", 32'(expBoot.size()), 32'd0);
      $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
